// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard controller signal bundle
// Purpose: groups the hazard inputs, pipeline control outputs and event
//   counters of hazard_stall_ctrl into one interface.
// Ports (as signals):
//   id_rs, id_rt, id_uses_rt        ID-stage source operands
//   ex_mem_read, ex_rt              EX-stage load and its destination
//   branch_taken, mem_busy, cnt_clr events and counter clear
//   pc_we, ifid_we, idex_we         pipeline register write enables
//   ifid_flush, bubble_se, pc_src_se flush / mux selects
//   stall_cnt, flush_cnt, freeze_cnt event counters
// Modports: master drives the events and observes the controls,
//   slave is the controller itself.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             branch_taken;
  logic             mem_busy;
  logic             cnt_clr;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             ifid_flush;
  logic             bubble_se;
  logic             pc_src_se;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, mem_busy, cnt_clr,
    input  pc_we, ifid_we, idex_we, ifid_flush, bubble_se, pc_src_se,
           stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           branch_taken, mem_busy, cnt_clr,
    output pc_we, ifid_we, idex_we, ifid_flush, bubble_se, pc_src_se,
           stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard / stall / flush controller
// Purpose: sequences the 5-stage pipe: load-use stalls, taken-branch
//   redirect and IF/ID flush, data-memory freezes; keeps saturating
//   event counters. Controls are combinational from state + inputs.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   hazard_stall_ctrl_if.slave (events in, controls/counters out)
module hazard_stall_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
);

  // fcnt only ever holds FLUSH_CYCLES-1 .. 1
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_FREEZE} state_t;

  state_t            state_q, state_n;
  state_t            ret_q, ret_n;
  logic [FC_W-1:0]   fcnt_q, fcnt_n;
  logic [CNT_W-1:0]  stall_q, flush_q, freeze_q;

  logic   load_use;
  state_t eff_state;
  logic   stall_inc, flush_inc, freeze_inc;

  assign load_use = bus.ex_mem_read && (bus.ex_rt != '0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // A released freeze acts as the state it interrupted, in the same cycle.
  assign eff_state = (state_q == S_FREEZE) ? ret_q : state_q;

  always_comb begin
    state_n        = state_q;
    ret_n          = ret_q;
    fcnt_n         = fcnt_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    freeze_inc     = 1'b0;
    bus.pc_we      = 1'b1;
    bus.ifid_we    = 1'b1;
    bus.idex_we    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.bubble_se  = 1'b0;
    bus.pc_src_se  = 1'b0;

    if (rst) begin
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.idex_we    = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.bubble_se  = 1'b1;
    end else if (bus.mem_busy) begin
      bus.pc_we   = 1'b0;
      bus.ifid_we = 1'b0;
      bus.idex_we = 1'b0;
      freeze_inc  = 1'b1;
      if (state_q != S_FREEZE) begin
        ret_n   = state_q;
        state_n = S_FREEZE;
      end
    end else if (bus.branch_taken) begin
      // Wrong-path load-use is irrelevant once the redirect happens.
      bus.pc_src_se  = 1'b1;
      bus.ifid_flush = 1'b1;
      bus.bubble_se  = 1'b1;
      flush_inc      = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = S_FLUSH;
        fcnt_n  = FC_W'(FLUSH_CYCLES - 1);
      end else begin
        state_n = S_RUN;
      end
    end else if (eff_state == S_FLUSH) begin
      bus.ifid_flush = 1'b1;
      bus.bubble_se  = 1'b1;
      fcnt_n         = fcnt_q - 1'b1;
      state_n        = (fcnt_q == FC_W'(1)) ? S_RUN : S_FLUSH;
    end else if (load_use) begin
      // One stall cycle suffices: the bubble sits in EX next cycle.
      bus.pc_we     = 1'b0;
      bus.ifid_we   = 1'b0;
      bus.bubble_se = 1'b1;
      stall_inc     = 1'b1;
      state_n       = S_RUN;
    end else begin
      state_n = S_RUN;
    end
  end

  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                               input logic inc,
                                               input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      ret_q    <= S_RUN;
      fcnt_q   <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      state_q  <= state_n;
      ret_q    <= ret_n;
      fcnt_q   <= fcnt_n;
      stall_q  <= cnt_upd(stall_q, stall_inc, bus.cnt_clr);
      flush_q  <= cnt_upd(flush_q, flush_inc, bus.cnt_clr);
      freeze_q <= cnt_upd(freeze_q, freeze_inc, bus.cnt_clr);
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;
  assign bus.freeze_cnt = freeze_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  // {pc_we, ifid_we, idex_we, ifid_flush, bubble_se, pc_src_se}
  localparam logic [5:0] C_RST   = 6'b000110;
  localparam logic [5:0] C_RUN   = 6'b111000;
  localparam logic [5:0] C_STALL = 6'b001010;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_FLUSH = 6'b111110;
  localparam logic [5:0] C_FRZ   = 6'b000000;

  localparam int K_STALL  = 0;
  localparam int K_FLUSH  = 1;
  localparam int K_FREEZE = 2;

  typedef struct {
    int          dut;
    string       name;
    bit          is_cnt;
    int          cnt_id;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst0, rst1, rst2;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) bus0 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(32)) bus1 ();
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  bus2 ();

  hazard_stall_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(bus0));
  hazard_stall_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));
  hazard_stall_ctrl #(.REG_W(5), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] act_ctl(input int d);
    case (d)
      0:       return {bus0.pc_we, bus0.ifid_we, bus0.idex_we,
                       bus0.ifid_flush, bus0.bubble_se, bus0.pc_src_se};
      1:       return {bus1.pc_we, bus1.ifid_we, bus1.idex_we,
                       bus1.ifid_flush, bus1.bubble_se, bus1.pc_src_se};
      default: return {bus2.pc_we, bus2.ifid_we, bus2.idex_we,
                       bus2.ifid_flush, bus2.bubble_se, bus2.pc_src_se};
    endcase
  endfunction

  function automatic logic [31:0] act_cnt(input int d, input int k);
    case (d)
      0:       return (k == K_STALL) ? bus0.stall_cnt :
                      (k == K_FLUSH) ? bus0.flush_cnt : bus0.freeze_cnt;
      1:       return (k == K_STALL) ? bus1.stall_cnt :
                      (k == K_FLUSH) ? bus1.flush_cnt : bus1.freeze_cnt;
      default: return (k == K_STALL) ? 32'(bus2.stall_cnt) :
                      (k == K_FLUSH) ? 32'(bus2.flush_cnt) : 32'(bus2.freeze_cnt);
    endcase
  endfunction

  // Monitor: every mid-cycle, compare whatever the stimulus queued.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = e.is_cnt ? act_cnt(e.dut, e.cnt_id) : 32'(act_ctl(e.dut));
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s dut%0d actual=%b expected=%b", e.name, e.dut,
                 act[5:0], e.val[5:0]);
        if (e.is_cnt)
          $display("FAIL %s dut%0d actual=%0d expected=%0d", e.name, e.dut, act, e.val);
      end
    end
  end

  task automatic drive(input int d, input bit r, input bit mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                       input bit br, input bit busy, input bit clr);
    case (d)
      0: begin
        rst0 = r; bus0.ex_mem_read = mr; bus0.ex_rt = ert; bus0.id_rs = rs;
        bus0.id_rt = rt; bus0.id_uses_rt = ur; bus0.branch_taken = br;
        bus0.mem_busy = busy; bus0.cnt_clr = clr;
      end
      1: begin
        rst1 = r; bus1.ex_mem_read = mr; bus1.ex_rt = ert; bus1.id_rs = rs;
        bus1.id_rt = rt; bus1.id_uses_rt = ur; bus1.branch_taken = br;
        bus1.mem_busy = busy; bus1.cnt_clr = clr;
      end
      default: begin
        rst2 = r; bus2.ex_mem_read = mr; bus2.ex_rt = ert; bus2.id_rs = rs;
        bus2.id_rt = rt; bus2.id_uses_rt = ur; bus2.branch_taken = br;
        bus2.mem_busy = busy; bus2.cnt_clr = clr;
      end
    endcase
  endtask

  task automatic idle(input int d);
    drive(d, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic stall(input int d);
    drive(d, 0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0);
  endtask

  task automatic exp_ctl(input int d, input string n, input logic [5:0] c);
    exp_t e;
    e.dut = d; e.name = n; e.is_cnt = 1'b0; e.cnt_id = 0; e.val = 32'(c);
    q.push_back(e);
  endtask

  task automatic exp_cnt(input int d, input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.dut = d; e.name = n; e.is_cnt = 1'b1; e.cnt_id = k; e.val = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) drive(d, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    tick();

    // Reset held two cycles on all three instances
    for (int d = 0; d < 3; d++) exp_ctl(d, "rst_ctl_c0", C_RST);
    tick();
    for (int d = 0; d < 3; d++) begin
      exp_ctl(d, "rst_ctl_c1", C_RST);
      exp_cnt(d, "rst_stall_cnt", K_STALL, 0);
      exp_cnt(d, "rst_flush_cnt", K_FLUSH, 0);
      exp_cnt(d, "rst_freeze_cnt", K_FREEZE, 0);
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      idle(d);
      exp_ctl(d, "release_run", C_RUN);
    end
    tick();

    // ---- dut0: FLUSH_CYCLES=2 ----
    stall(0);                                   exp_ctl(0, "lu_rs", C_STALL);
    exp_cnt(0, "lu_cnt_before", K_STALL, 0);    tick();
    idle(0);                                    exp_ctl(0, "after_lu", C_RUN);
    exp_cnt(0, "lu_cnt_after", K_STALL, 1);     tick();
    drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    exp_ctl(0, "lu_rt0_none", C_RUN);           tick();
    drive(0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0);
    exp_ctl(0, "lu_rt_unused", C_RUN);
    exp_cnt(0, "lu_no_inc", K_STALL, 1);        tick();
    drive(0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0, 0);
    exp_ctl(0, "lu_rt_used", C_STALL);          tick();
    idle(0);                                    exp_ctl(0, "run_a", C_RUN);
    exp_cnt(0, "lu_cnt_2", K_STALL, 2);         tick();

    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    exp_ctl(0, "br_n", C_BR);                   tick();
    idle(0);                                    exp_ctl(0, "br_n1_flush", C_FLUSH);
    exp_cnt(0, "br_flush_cnt1", K_FLUSH, 1);    tick();
    exp_ctl(0, "br_n2_run", C_RUN);             tick();

    drive(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
    exp_ctl(0, "br_lu_redirect", C_BR);         tick();
    idle(0);                                    exp_ctl(0, "br_lu_flush", C_FLUSH);
    exp_cnt(0, "br_lu_stall_same", K_STALL, 2);
    exp_cnt(0, "br_lu_flush_cnt", K_FLUSH, 2);  tick();
    exp_ctl(0, "br_lu_run", C_RUN);             tick();

    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    exp_ctl(0, "br_first", C_BR);               tick();
    exp_ctl(0, "br_in_flush", C_BR);            tick();
    idle(0);                                    exp_ctl(0, "br_restart_flush", C_FLUSH);
    tick();
    exp_ctl(0, "br_restart_run", C_RUN);
    exp_cnt(0, "br_flush_cnt4", K_FLUSH, 4);    tick();

    drive(0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0);
    exp_ctl(0, "frz_lu_ignored", C_FRZ);        tick();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
    exp_ctl(0, "frz_br_ignored", C_FRZ);        tick();
    idle(0);                                    exp_ctl(0, "frz_release_run", C_RUN);
    exp_cnt(0, "frz_cnt2", K_FREEZE, 2);
    exp_cnt(0, "frz_flush_same", K_FLUSH, 4);
    exp_cnt(0, "frz_stall_same", K_STALL, 2);   tick();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    exp_ctl(0, "clr_run", C_RUN);               tick();
    idle(0);
    exp_cnt(0, "clr_freeze", K_FREEZE, 0);
    exp_cnt(0, "clr_flush", K_FLUSH, 0);        tick();

    // ---- dut1: FLUSH_CYCLES=3, freeze mid-flush ----
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    exp_ctl(1, "f3_br", C_BR);                  tick();
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    exp_ctl(1, "f3_frz1", C_FRZ);               tick();
    drive(1, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0);
    exp_ctl(1, "f3_frz2", C_FRZ);               tick();
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    exp_ctl(1, "f3_frz3", C_FRZ);               tick();
    idle(1);                                    exp_ctl(1, "f3_flush1", C_FLUSH);
    exp_cnt(1, "f3_freeze_cnt", K_FREEZE, 3);   tick();
    exp_ctl(1, "f3_flush2", C_FLUSH);           tick();
    exp_ctl(1, "f3_run", C_RUN);                tick();

    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    exp_ctl(1, "rstmid_br", C_BR);              tick();
    idle(1);                                    exp_ctl(1, "rstmid_flush", C_FLUSH);
    tick();
    drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    exp_ctl(1, "rstmid_rst", C_RST);            tick();
    idle(1);                                    exp_ctl(1, "rstmid_run", C_RUN);
    exp_cnt(1, "rstmid_flush_cnt", K_FLUSH, 0); tick();
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
    exp_ctl(1, "rstfrz_frz", C_FRZ);            tick();
    drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    exp_ctl(1, "rstfrz_rst", C_RST);            tick();
    idle(1);                                    exp_ctl(1, "rstfrz_run", C_RUN);
    tick();

    // ---- dut2: FLUSH_CYCLES=1, CNT_W=4 ----
    drive(2, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
    exp_ctl(2, "f1_br", C_BR);                  tick();
    idle(2);                                    exp_ctl(2, "f1_no_flush_state", C_RUN);
    exp_cnt(2, "f1_flush_cnt", K_FLUSH, 1);     tick();
    for (int i = 0; i < 20; i++) begin
      stall(2);
      exp_ctl(2, "sat_stall_ctl", C_STALL);
      exp_cnt(2, "sat_stall_cnt", K_STALL, (i < 15) ? 32'(i) : 32'd15);
      tick();
    end
    drive(2, 0, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 1);
    exp_ctl(2, "clr_with_stall", C_STALL);
    exp_cnt(2, "sat_final", K_STALL, 15);       tick();
    idle(2);                                    exp_ctl(2, "clr_after_run", C_RUN);
    exp_cnt(2, "clr_wins", K_STALL, 0);         tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
